// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execution stage with an iterative serial shifter
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHIFT_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [3:0]       alu_control_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             busy_o
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW:0] SPC = (CW+1)'(SHIFT_PER_CYCLE);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] code_q;
  logic [WIDTH-1:0] work_q, work_nx, b_q, result_nx, shifted;
  logic signed [WIDTH-1:0] sra;
  logic [CW-1:0] rem_q, rem_nx, step;
  logic accept, load_res;
  function automatic logic is_shift(input logic [3:0] c);
    return c >= 4'd6 && c <= 4'd8;
  endfunction
  function automatic logic [WIDTH-1:0] alu(input logic [3:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return c == 4'd0 ? a + b :
           c == 4'd1 ? a - b :
           c == 4'd2 ? a & b :
           c == 4'd3 ? a | b :
           c == 4'd4 ? a ^ b :
           c == 4'd5 ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} : '0;
  endfunction
  assign step = ({1'b0, rem_q} < SPC) ? rem_q : SPC[CW-1:0];
  assign sra = $signed(work_q) >>> step;
  assign shifted = code_q == 4'd6 ? work_q << step : code_q == 4'd7 ? work_q >> step : sra;
  assign res_valid_o = state == DONE;
  assign busy_o = state != IDLE;
  // A new op accepted while DONE takes a bubble through SHIFT so res_valid_o drops between results
  always_comb begin
    state_nx = state;
    work_nx = work_q;
    rem_nx = rem_q;
    result_nx = result_o;
    load_res = 1'b0;
    op_ready_o = !flush_i && (state == IDLE || (state == DONE && res_ready_i));
    accept = op_valid_i && op_ready_o;
    if (flush_i) state_nx = IDLE;
    else if (accept) begin
      work_nx = src_a_i;
      rem_nx = is_shift(alu_control_i) ? src_b_i[CW-1:0] : '0;
      if (state == DONE || rem_nx != '0) state_nx = SHIFT;
      else begin
        state_nx = DONE;
        load_res = 1'b1;
        result_nx = is_shift(alu_control_i) ? src_a_i : alu(alu_control_i, src_a_i, src_b_i);
      end
    end else if (state == DONE && res_ready_i) state_nx = IDLE;
    else if (state == SHIFT) begin
      work_nx = shifted;
      rem_nx = rem_q - step;
      if (rem_nx == '0) begin
        state_nx = DONE;
        load_res = 1'b1;
        result_nx = is_shift(code_q) ? shifted : alu(code_q, work_q, b_q);
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      work_q <= '0;
      rem_q <= '0;
      code_q <= '0;
      b_q <= '0;
      result_o <= '0;
      zero_o <= 1'b1;
    end else begin
      state <= state_nx;
      work_q <= work_nx;
      rem_q <= rem_nx;
      if (accept) begin
        code_q <= alu_control_i;
        b_q <= src_b_i;
      end
      if (load_res) begin
        result_o <= result_nx;
        zero_o <= result_nx == '0;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors plus a scoreboard of architectural results checked every cycle
module tb_alu_exec_unit;
  logic clk = 0, rst_n = 0, flush = 0, op_valid = 0, res_ready = 1;
  logic op_ready, res_valid, zero, busy;
  logic [3:0] code = 0;
  logic [31:0] a = 0, b = 0, result;
  int passed = 0, total = 0;
  logic [31:0] exp_q[$];
  logic hold = 0;
  logic [31:0] held = 0;
  always #5 clk = ~clk;
  alu_exec_unit dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .op_valid_i(op_valid), .op_ready_o(op_ready),
    .alu_control_i(code), .src_a_i(a), .src_b_i(b), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .result_o(result), .zero_o(zero), .busy_o(busy)
  );
  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y[4:0]);
    case (c)
      4'd0: model = x + y;
      4'd1: model = x - y;
      4'd2: model = x & y;
      4'd3: model = x | y;
      4'd4: model = x ^ y;
      4'd5: model = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6: model = x << sh;
      4'd7: model = x >> sh;
      4'd8: model = $signed(x) >>> sh;
      default: model = 32'd0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold = 0;
    end else begin
      chk("zero_flag", zero, result == 32'd0);
      chk("op_ready_rule", op_ready, !flush && (!busy || (res_valid && res_ready)));
      if (hold) chk("result_stable", result, held);
      if (res_valid) chk("valid_has_op", exp_q.size() != 0, 1);
      if (flush) exp_q.delete();
      else begin
        if (res_valid && res_ready && exp_q.size() != 0) chk("scoreboard", result, exp_q.pop_front());
        if (op_valid && op_ready) exp_q.push_back(model(code, a, b));
      end
      hold = res_valid && !res_ready && !flush;
      held = result;
    end
  end
  task automatic run_op(input string name, input logic [3:0] c, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] exp_r, input int exp_lat);
    int n;
    chk({name, "_model"}, model(c, aa, bb), exp_r);
    @(posedge clk); #1;
    code = c; a = aa; b = bb; op_valid = 1; res_ready = 1;
    chk({name, "_ready"}, op_ready, 1);
    @(posedge clk); #1;
    op_valid = 0; a = $urandom; b = $urandom; code = 4'($urandom);
    n = 1;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_lat"}, n, exp_lat);
    chk({name, "_res"}, result, exp_r);
    chk({name, "_zero"}, zero, exp_r == 32'd0);
  endtask
  initial begin
    int n;
    logic seen;
    #12;
    chk("rst_result", result, 0);
    chk("rst_zero", zero, 1);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    #1 chk("rst_ready", op_ready, 1);
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1);
    run_op("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_op("and", 4'd2, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
    run_op("or", 4'd3, 32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 1);
    run_op("xor", 4'd4, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
    run_op("slt_neg", 4'd5, 32'h8000_0000, 32'd1, 32'd1, 1);
    run_op("slt_pos", 4'd5, 32'd1, 32'h8000_0000, 32'd0, 1);
    run_op("reserved", 4'd12, 32'd5, 32'd9, 32'd0, 1);
    run_op("sra31", 4'd8, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32);
    run_op("srl31", 4'd7, 32'h8000_0000, 32'd31, 32'h0000_0001, 32);
    run_op("sll0", 4'd6, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1);
    run_op("sll4", 4'd6, 32'd1, 32'd4, 32'd16, 5);
    run_op("sra4", 4'd8, 32'hF000_0000, 32'd4, 32'hFF00_0000, 5);
    run_op("sll_mask", 4'd6, 32'd1, 32'h21, 32'd2, 2);
    // backpressure, then back-to-back accept on release
    @(posedge clk); #1;
    code = 4'd0; a = 32'd3; b = 32'd4; op_valid = 1; res_ready = 0;
    @(posedge clk); #1;
    code = 4'd4; a = 32'h0000_00F0; b = 32'h0000_00FF;
    chk("bp_valid", res_valid, 1);
    chk("bp_res", result, 32'd7);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold", result, 32'd7);
      chk("bp_not_ready", op_ready, 0);
    end
    res_ready = 1;
    #1 chk("b2b_ready", op_ready, 1);
    @(posedge clk); #1;
    op_valid = 0;
    chk("b2b_drop", res_valid, 0);
    n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_res", result, 32'h0000_000F);
    // flush mid-shift
    @(posedge clk); #1;
    code = 4'd6; a = 32'd1; b = 32'd20; op_valid = 1;
    @(posedge clk); #1;
    op_valid = 0;
    repeat (3) @(posedge clk);
    #1 flush = 1;
    #1 chk("flush_not_ready", op_ready, 0);
    @(posedge clk); #1;
    flush = 0;
    chk("flush_idle", busy, 0);
    chk("flush_valid", res_valid, 0);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      seen |= res_valid;
    end
    chk("flush_no_pulse", seen, 0);
    run_op("post_flush", 4'd6, 32'd1, 32'd3, 32'd8, 4);
    // async reset in the middle of a shift
    @(posedge clk); #1;
    code = 4'd8; a = 32'h8000_0000; b = 32'd31; op_valid = 1;
    @(posedge clk); #1;
    op_valid = 0;
    repeat (5) @(posedge clk);
    #1 chk("pre_rst_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_zero", zero, 1);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1;
    #1 chk("mid_rst_ready", op_ready, 1);
    run_op("post_rst", 4'd1, 32'd10, 32'd3, 32'd7, 1);
    repeat (3) @(posedge clk);
    #1 chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
